// File: rtl/alu_rr_arbiter.sv
// Round-robin sequencer sharing one start/done ALU among NUM_REQ requesters.
// Latency: accept T, alu_start T+1, done edge at D -> rsp_valid D+1 (bad op: T+1).
// Backpressure: one request in flight; req_ready only in IDLE, losers hold their request.
module alu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [3*NUM_REQ-1:0] req_op,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [15:0]          rsp_result,
    output logic                 rsp_error,
    output logic                 busy,
    output logic                 alu_start,
    output logic [2:0]           alu_op,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    input  logic                 alu_done,
    input  logic [15:0]          alu_result
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [2:0] OP_BAD = 3'b111;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] owner;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;
    logic          win_found;
    logic [2:0]    win_op;
    logic [7:0]    win_a;
    logic [7:0]    win_b;
    logic          accept;
    logic          done_q;
    logic          done_edge;
    logic          timed_out;
    logic [15:0]   timer;

    // Only a fresh rising edge of done counts; a level left over from a prior op is ignored.
    assign done_edge = alu_done & ~done_q;
    assign timed_out = (timer == 16'(TIMEOUT - 1));
    assign accept    = (state == IDLE) && win_found && !reset;

    // Rotating-priority scan starting just after the last served requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        win_op    = '0;
        win_a     = '0;
        win_b     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(last_grant) + k) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
                win_op    = req_op[3*int'(cand) +: 3];
                win_a     = req_a[8*int'(cand) +: 8];
                win_b     = req_b[8*int'(cand) +: 8];
            end
        end
    end

    // One-hot accept strobe to the winner, only while idle.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; completion takes precedence over timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (win_op == OP_BAD) ? RESP : ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (done_edge || timed_out) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs: start pulse, busy flag and the owner's response strobe.
    always_comb begin
        alu_start = (state == ISSUE);
        busy      = (state != IDLE);
        rsp_valid = '0;
        if (state == RESP) begin
            rsp_valid[owner] = 1'b1;
        end
    end

    // Datapath: capture the winner's operands, run the wait timer, latch the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= IW'(NUM_REQ - 1);
            owner      <= '0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_result <= '0;
            rsp_error  <= 1'b0;
            timer      <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= alu_done;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner  <= win_idx;
                        alu_op <= win_op;
                        alu_a  <= win_a;
                        alu_b  <= win_b;
                        if (win_op == OP_BAD) begin
                            rsp_result <= '0;
                            rsp_error  <= 1'b1;
                        end
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    if (done_edge) begin
                        rsp_result <= alu_result;
                        rsp_error  <= 1'b0;
                    end else if (timed_out) begin
                        rsp_result <= '0;
                        rsp_error  <= 1'b1;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                RESP: last_grant <= owner;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: directed requests, ALU behavioural model, response scoreboard.
// Latency of responses is checked against accept cycle where the behaviour fixes it.
// Requesters hold valid until accepted; the ALU model can stall, hold done, or go silent.
module tb_alu_rr_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [3*N-1:0] req_op;
    logic [8*N-1:0] req_a;
    logic [8*N-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [15:0]    rsp_result;
    logic           rsp_error;
    logic           busy;
    logic           alu_start;
    logic [2:0]     alu_op;
    logic [7:0]     alu_a;
    logic [7:0]     alu_b;
    logic           alu_done   = 1'b0;
    logic [15:0]    alu_result = 16'h0;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .rsp_error(rsp_error), .busy(busy), .alu_start(alu_start),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result)
    );

    typedef struct packed {
        logic [N-1:0] who;
        logic [15:0]  res;
        logic         err;
    } exp_t;

    exp_t         sb[$];
    int           n_checks  = 0;
    int           n_pass    = 0;
    int           cyc       = 0;
    int           start_cnt = 0;
    int           acc_cyc   = 0;
    int           rsp_cyc   = 0;
    logic [N-1:0] last_acc;
    logic         alu_en    = 1'b1;
    logic         hold      = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Behavioural ALU: done rises 3 cycles after start; with hold set, done stays high
    // until the next op, where it stays stale one more cycle, falls, then rises again.
    logic [1:0]  m_cnt  = 2'd0;
    logic        m_busy = 1'b0;
    logic [15:0] m_res  = 16'h0;

    function automatic logic [15:0] alu_fn(logic [2:0] op, logic [7:0] a, logic [7:0] b);
        case (op)
            3'b000:  return 16'(a) + 16'(b);
            3'b001:  return 16'(a) - 16'(b);
            3'b010:  return 16'(a) * 16'(b);
            3'b011:  return (b == 8'd0) ? 16'hFFFF : 16'(a / b);
            3'b100:  return 16'(a ^ b);
            default: return 16'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (alu_start && alu_en) begin
            m_cnt  <= 2'd1;
            m_busy <= 1'b1;
            m_res  <= alu_fn(alu_op, alu_a, alu_b);
        end else if (m_busy) begin
            if (m_cnt == 2'd1) begin
                alu_done <= 1'b0;
                m_cnt    <= 2'd2;
            end else begin
                alu_done   <= 1'b1;
                alu_result <= m_res;
                m_busy     <= 1'b0;
            end
        end else if (!hold) begin
            alu_done <= 1'b0;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (alu_start) start_cnt++;

    // Monitor: every response pops the oldest expectation and is compared against it.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid != '0) begin
            rsp_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid), 32'h0);
            end else begin
                e = sb.pop_front();
                check("rsp_owner",  32'(rsp_valid),  32'(e.who));
                check("rsp_result", 32'(rsp_result), 32'(e.res));
                check("rsp_error",  32'(rsp_error),  32'(e.err));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        last_acc = req_valid & req_ready;
        if (last_acc != '0) acc_cyc = cyc;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~last_acc;
    endtask

    task automatic set_req(int i, logic [2:0] op, logic [7:0] a, logic [7:0] b);
        req_valid[i]       = 1'b1;
        req_op[3*i +: 3]   = op;
        req_a[8*i +: 8]    = a;
        req_b[8*i +: 8]    = b;
    endtask

    task automatic expect_rsp(int i, logic [15:0] r, logic e);
        exp_t x;
        x.who    = '0;
        x.who[i] = 1'b1;
        x.res    = r;
        x.err    = e;
        sb.push_back(x);
    endtask

    task automatic wait_done(string name);
        bit ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (req_valid == '0 && !busy && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'h1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int  s0;
        bit  seen;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        do_reset();

        // Reset state
        @(negedge clk);
        check("reset_busy",      32'(busy),       32'h0);
        check("reset_req_ready", 32'(req_ready),  32'h0);
        check("reset_rsp_valid", 32'(rsp_valid),  32'h0);
        check("reset_alu_start", 32'(alu_start),  32'h0);
        check("reset_alu_bus",   {13'h0, alu_op, alu_a, alu_b}, 32'h0);
        check("reset_rsp_data",  {15'h0, rsp_error, rsp_result}, 32'h0);
        @(posedge clk); #1;

        // 1: single ADD from requester 0
        s0 = start_cnt;
        set_req(0, 3'b000, 8'd25, 8'd17);
        expect_rsp(0, 16'd42, 1'b0);
        wait_done("t1_complete");
        check("t1_start_pulses", 32'(start_cnt - s0), 32'd1);
        check("t1_latency",      32'(rsp_cyc - acc_cyc), 32'd5);

        // 2: all four at once from a fresh rotation pointer, then 0 and 2 again
        do_reset();
        set_req(0, 3'b010, 8'd6,   8'd9);
        set_req(1, 3'b001, 8'd42,  8'd15);
        set_req(2, 3'b011, 8'd100, 8'd4);
        set_req(3, 3'b100, 8'hAA,  8'hCC);
        expect_rsp(0, 16'd54, 1'b0);
        expect_rsp(1, 16'd27, 1'b0);
        expect_rsp(2, 16'd25, 1'b0);
        expect_rsp(3, 16'h0066, 1'b0);
        wait_done("t2_all_four");
        set_req(0, 3'b000, 8'd1,  8'd2);
        set_req(2, 3'b001, 8'd10, 8'd3);
        expect_rsp(0, 16'd3, 1'b0);
        expect_rsp(2, 16'd7, 1'b0);
        wait_done("t2_rerequest");

        // 3: unsupported op from requester 1 (pointer at 2 -> 3,0,1)
        s0 = start_cnt;
        set_req(1, 3'b111, 8'd5, 8'd6);
        expect_rsp(1, 16'd0, 1'b1);
        tick();
        check("t3_ready", 32'(last_acc), 32'b0010);
        @(negedge clk);
        check("t3_rsp_next_cycle", 32'(rsp_valid), 32'b0010);
        check("t3_no_start", 32'(start_cnt - s0), 32'd0);
        @(posedge clk); #1;
        wait_done("t3_complete");

        // 4: ALU silent -> timeout after TO cycles of WAIT
        alu_en = 1'b0;
        set_req(2, 3'b000, 8'd1, 8'd1);
        expect_rsp(2, 16'd0, 1'b1);
        tick();
        check("t4_ready", 32'(last_acc), 32'b0100);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                seen = 1'b1;
                break;
            end
        end
        check("t4_rsp_seen", 32'(seen), 32'h1);
        check("t4_timeout_latency", 32'(cyc - acc_cyc), 32'd10);
        @(negedge clk);
        check("t4_busy_drop", 32'(busy), 32'h0);
        @(posedge clk); #1;
        alu_en = 1'b1;

        // 5: done held high from the previous op must not complete the next one
        hold = 1'b1;
        set_req(3, 3'b000, 8'd10, 8'd20);
        set_req(0, 3'b010, 8'd3,  8'd4);
        expect_rsp(3, 16'd30, 1'b0);
        expect_rsp(0, 16'd12, 1'b0);
        wait_done("t5_stale_done");
        hold = 1'b0;

        // 6: reset during WAIT drops the response and restores priority to requester 0
        set_req(1, 3'b000, 8'd7, 8'd8);
        tick();
        check("t6_ready", 32'(last_acc), 32'b0010);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_busy",      32'(busy),      32'h0);
        check("t6_rsp_valid", 32'(rsp_valid), 32'h0);
        check("t6_alu_bus",   {12'h0, alu_start, alu_op, alu_a, alu_b}, 32'h0);
        check("t6_rsp_data",  {15'h0, rsp_error, rsp_result}, 32'h0);
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) tick();
        set_req(0, 3'b000, 8'd2, 8'd3);
        set_req(1, 3'b001, 8'd9, 8'd4);
        expect_rsp(0, 16'd5, 1'b0);
        expect_rsp(1, 16'd5, 1'b0);
        wait_done("t6_after_reset");

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Round-robin arbiter/sequencer that shares one alu_top instance (start/done handshake, 8-bit operands, 16-bit result) among NUM_REQ requesters. It accepts one request at a time and pulses alu_start. It waits for a rising edge of alu_done, with a timeout, then returns the result to the owning requester. It sits between the requester blocks and alu_top, and is the only driver of alu_top's start/op/in_a/in_b.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 255, max cycles in WAIT before aborting with error (1..65535)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request pending
req_op  in  3*NUM_REQ  op of requester i at bits [3i+2:3i]
req_a  in  8*NUM_REQ  operand A of requester i at [8i+7:8i]
req_b  in  8*NUM_REQ  operand B of requester i at [8i+7:8i]
req_ready  out  NUM_REQ  one-hot accept; transfer when req_valid[i] & req_ready[i]
rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse to owner
rsp_result  out  16  result for current response
rsp_error  out  1  response is an error (bad op or timeout)
busy  out  1  high in every state except IDLE
alu_start  out  1  one-cycle start pulse to alu_top
alu_op  out  3  op to alu_top
alu_a  out  8  in_a to alu_top
alu_b  out  8  in_b to alu_top
alu_done  in  1  done from alu_top
alu_result  in  16  result from alu_top

Behaviour:
- Reset: state=IDLE. Outputs req_ready, rsp_valid, rsp_result, rsp_error, busy, alu_start, alu_op, alu_a and alu_b are all 0. last_grant=NUM_REQ-1, so requester 0 has top priority first. Timer=0, done_q=0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i] set, scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready is combinational: one-hot of the winner, asserted only in IDLE, zero when no request is valid.
  - On accept: owner=winner; op/a/b are registered into alu_op/alu_a/alu_b.
  - If op==3'b111 (unsupported), go to RESP with error and never pulse alu_start. Otherwise go to ISSUE.
- ISSUE:
  - alu_start=1 for exactly this cycle; timer cleared.
  - alu_op/alu_a/alu_b hold stable from accept until RESP exits.
  - Next state is WAIT.
- WAIT:
  - Completion = alu_done & ~done_q, where done_q is alu_done registered every cycle. A done level left high from a previous operation is ignored.
  - On completion: capture alu_result into rsp_result, rsp_error=0, go to RESP.
  - Otherwise timer increments. When timer==TIMEOUT-1 without completion: rsp_result=0, rsp_error=1, go to RESP.
  - Completion wins over timeout in the same cycle.
- RESP:
  - rsp_valid[owner]=1 for exactly one cycle, with rsp_result/rsp_error valid in that cycle.
  - last_grant=owner; next state is IDLE.
  - rsp_result/rsp_error hold until the next RESP; rsp_valid is 0 elsewhere.
- Latency: accept at cycle T; alu_start at T+1; completion edge sampled at cycle D gives rsp_valid at D+1. Earliest next accept is D+2. Bad op: accept at T, rsp_valid at T+1.
- Fairness: a requester that was just served has lowest priority next round. A requester held valid is served within NUM_REQ grants.
- Requests not granted are untouched; requesters must hold req_valid and operands until accepted.
- reset asserted in any state: return to reset values next cycle. An in-flight response is dropped (no rsp_valid) and last_grant is reinitialised.

Test Plan:
1. Requester 0 sends ADD(000), a=25, b=17; alu model with done 3 cycles after start -> exactly one alu_start pulse; rsp_valid=0001, rsp_result=42, rsp_error=0.
2. All four req_valid high at once: ops MUL 6*9, SUB 42-15, DIV 100/4, XOR AA^CC -> grants in order 0,1,2,3; results 54, 27, 25, 0x0066. Then requesters 0 and 2 re-request after requester 3 is served -> 0 is served before 2.
3. Requester 1 sends op=111 -> req_ready[1] pulses; no alu_start; next cycle rsp_valid=0010, rsp_error=1, rsp_result=0.
4. alu_done tied low, TIMEOUT=8 -> rsp_error=1 and rsp_result=0 exactly 8 cycles after entering WAIT; busy drops the cycle after RESP.
5. alu_done stuck high from the previous op, and the new op's done rises only after falling first -> the response uses the new edge, not the stale level.
6. reset pulsed for one cycle mid-WAIT -> no rsp_valid; all outputs 0; a following request from requester 0 is granted first.
